seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side companion to the multiplexed 4-digit seven-segment driver. The block samples the segment and anode lines as the driver scans them, maps each lit-segment pattern back to its hex nibble, and reassembles the 16-bit value once every digit has been captured. It sits on-chip beside the display driver as a loop-back self-check. It can also sit in a bench harness that monitors the display outputs.

## Interface
Parameters:
- STABLE_CNT, 1: consecutive identical samples of a digit (same anode index, same pattern) required before the nibble is accepted; legal range 1..15.
- TIMEOUT, 1024: cycles without a completed frame before `stale` asserts; legal range 2..65535.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  segment lines, active-high (1 = lit), bit 6 = a … bit 0 = g.
- anodes_in  input  4  digit enables, active-low one-hot; bit 0 = least significant digit.
- value  output  16  last completely assembled word, digit 3 in [15:12].
- value_valid  output  1  single-cycle pulse when `value` is updated.
- digit_err  output  1  single-cycle pulse on an undecodable sample.
- stale  output  1  level; high while no frame has completed for TIMEOUT cycles.

## Operation
- Decode table (seg_in → nibble):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001.
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000.
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111.
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111.
- Anode classes:
  - Exactly one bit low: active digit index 0..3.
  - 4'b1111: blank. The sample is ignored and no state changes, except the timeout counter.
  - Any other value: illegal.
- Error sample: illegal anodes, or a one-hot anode with a pattern not in the table.
  - `digit_err` pulses.
  - The stability counter clears.
  - The seen bit of the addressed digit clears; illegal anodes clear all seen bits.
  - Nothing is written to shadow.
- Stability counter (4 bits):
  - Valid sample equal to the previous valid sample (index and nibble): counter increments, saturating at STABLE_CNT.
  - Otherwise: counter loads 1.
  - The sample is accepted on the cycle the counter reaches STABLE_CNT; with STABLE_CNT = 1, every valid sample is accepted.
- Acceptance: writes `shadow[index]` and sets `seen[index]`. Re-accepting an already-seen digit overwrites its shadow nibble.
- Frame completion: when `seen | (1 << index)` equals 4'b1111 at acceptance:
  - `value` loads shadow with the current nibble bypassed into its slot.
  - `value_valid` pulses.
  - `seen` clears to 4'b0000.
- Timeout counter:
  - Clears on frame completion.
  - Otherwise increments, saturating at TIMEOUT.
  - `stale` = (counter == TIMEOUT).

## Timing
- Decode is combinational from the inputs. All outputs are registered.
- `value`, `value_valid` and `digit_err` reflect the sample taken at edge N during the cycle after edge N.
- With a driver rotating every cycle and STABLE_CNT = 1: `value_valid` follows the fourth distinct digit by one cycle. Steady-state frame rate is one per 4 cycles.
- Simultaneous completion and timeout saturation: completion wins; the counter clears and `stale` drops on the same edge.
- Reset values (applied immediately on rst_n low):
  - `value` = 16'h0000; `value_valid` = 0; `digit_err` = 0; `stale` = 0.
  - `seen` = 0; shadow = 0; stability and timeout counters = 0.
- Reset mid-frame discards partial digits. The first frame after release needs all four digits again.

## Configuration
- SEGDEC_ALIAS_EN defined: two alternate glyphs are also accepted.
  - 1110010 decodes as 7 (with f segment).
  - 1110011 decodes as 9 (without d segment).
- Not defined: those two patterns are error samples.

## Test plan
- Rotate digits F/1110, A/1101, 2/1011, 1/0111, one per cycle, STABLE_CNT = 1 → one `value_valid` pulse the cycle after the 4th sample; `value` = 16'h12AF; pulses repeat every 4 cycles.
- STABLE_CNT = 3, each digit held 2 cycles → no acceptance and no `value_valid`; after TIMEOUT cycles `stale` = 1. Hold each digit 3 cycles → frame completes and `stale` drops.
- Inject seg_in = 0000001 on digit 2 mid-frame → `digit_err` pulses once; completion waits until digit 2 is re-accepted.
- Inject anodes_in = 4'b1100 → `digit_err` pulses and all seen bits clear. Inject anodes_in = 4'b1111 → ignored, no pulse.
- Pattern 1110011 on digit 0 → with SEGDEC_ALIAS_EN, nibble 9 is accepted; without it, `digit_err` pulses.
- Assert rst_n low after 3 digits, then release and drive 4 digits → all outputs are 0 during reset; exactly one `value_valid` with the new word, and no mix of pre-reset nibbles.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit seven-segment display
// (active-high segments a..g on seg_in[6:0], active-low one-hot anodes) and
// reassembles the displayed 16-bit hex word once all four digits have been
// captured with a stable pattern.
// Optional feature macro: SEGDEC_ALIAS_EN accepts the alternate glyphs
// 1110010 (7 with f segment) and 1110011 (9 without d segment).
module seg_scan_decoder #(
    parameter int STABLE_CNT = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  anodes_in,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        digit_err,
    output logic        stale
);

    localparam logic [3:0]  STABLE_MAX  = 4'(STABLE_CNT);
    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT);

    // Maps a segment pattern to {decodable, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1111011: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b1001110: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1001111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
`ifdef SEGDEC_ALIAS_EN
            7'b1110010: r = {1'b1, 4'h7};
            7'b1110011: r = {1'b1, 4'h9};
`endif
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [1:0]  idx_s;
    logic        onehot_s;
    logic        blank_s;
    logic [4:0]  dec_s;

    logic [3:0]  seen_d, seen_q;
    logic [15:0] shadow_d, shadow_q;
    logic [3:0]  stab_cnt_d, stab_cnt_q;
    logic [1:0]  last_idx_d, last_idx_q;
    logic [3:0]  last_nib_d, last_nib_q;
    logic [15:0] timeout_d, timeout_q;
    logic [15:0] value_d, value_q;
    logic        value_valid_d, value_valid_q;
    logic        digit_err_d, digit_err_q;
    logic        stale_d, stale_q;
    logic        frame_done_s;

    // Classify the anode lines into a digit index, blank, or illegal.
    always_comb begin
        idx_s    = 2'd0;
        onehot_s = 1'b0;
        blank_s  = 1'b0;
        case (anodes_in)
            4'b1110: begin idx_s = 2'd0; onehot_s = 1'b1; end
            4'b1101: begin idx_s = 2'd1; onehot_s = 1'b1; end
            4'b1011: begin idx_s = 2'd2; onehot_s = 1'b1; end
            4'b0111: begin idx_s = 2'd3; onehot_s = 1'b1; end
            4'b1111: blank_s = 1'b1;
            default: onehot_s = 1'b0;
        endcase
        dec_s = seg_decode(seg_in);
    end

    // Next-state: stability filtering, digit capture, frame assembly, timeout.
    always_comb begin
        seen_d        = seen_q;
        shadow_d      = shadow_q;
        stab_cnt_d    = stab_cnt_q;
        last_idx_d    = last_idx_q;
        last_nib_d    = last_nib_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        digit_err_d   = 1'b0;
        frame_done_s  = 1'b0;

        if (blank_s) begin
            // Blank scan slot: hold everything.
            seen_d = seen_q;
        end else if (!onehot_s) begin
            digit_err_d = 1'b1;
            stab_cnt_d  = 4'd0;
            seen_d      = 4'b0000;
        end else if (!dec_s[4]) begin
            digit_err_d   = 1'b1;
            stab_cnt_d    = 4'd0;
            seen_d[idx_s] = 1'b0;
        end else begin
            last_idx_d = idx_s;
            last_nib_d = dec_s[3:0];
            // A cleared counter (after reset or an error) restarts at 1 either way.
            if ((idx_s == last_idx_q) && (dec_s[3:0] == last_nib_q)) begin
                if (stab_cnt_q >= STABLE_MAX) begin
                    stab_cnt_d = STABLE_MAX;
                end else begin
                    stab_cnt_d = stab_cnt_q + 4'd1;
                end
            end else begin
                stab_cnt_d = 4'd1;
            end
            if (stab_cnt_d == STABLE_MAX) begin
                shadow_d[{idx_s, 2'b00} +: 4] = dec_s[3:0];
                if ((seen_q | (4'b0001 << idx_s)) == 4'b1111) begin
                    // shadow_d already carries the current nibble in its slot.
                    value_d       = shadow_d;
                    value_valid_d = 1'b1;
                    seen_d        = 4'b0000;
                    frame_done_s  = 1'b1;
                end else begin
                    seen_d[idx_s] = 1'b1;
                end
            end else begin
                shadow_d = shadow_q;
            end
        end

        // Completion takes priority over saturation so stale drops immediately.
        if (frame_done_s) begin
            timeout_d = 16'd0;
        end else if (timeout_q != TIMEOUT_MAX) begin
            timeout_d = timeout_q + 16'd1;
        end else begin
            timeout_d = timeout_q;
        end
        stale_d = (timeout_d == TIMEOUT_MAX);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q        <= 4'b0000;
            shadow_q      <= 16'h0000;
            stab_cnt_q    <= 4'd0;
            last_idx_q    <= 2'd0;
            last_nib_q    <= 4'd0;
            timeout_q     <= 16'd0;
            value_q       <= 16'h0000;
            value_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            stab_cnt_q    <= stab_cnt_d;
            last_idx_q    <= last_idx_d;
            last_nib_q    <= last_nib_d;
            timeout_q     <= timeout_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            digit_err_q   <= digit_err_d;
            stale_q       <= stale_d;
        end
    end

    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign digit_err   = digit_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed testbench for seg_scan_decoder: one instance with STABLE_CNT=1,
// one with STABLE_CNT=3 and a short timeout.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg1, seg3;
    logic [3:0]  an1, an3;
    logic [15:0] value1, value3;
    logic        valid1, valid3, err1, err3, stale1, stale3;

    int checks = 0;
    int errors = 0;

    // Rotation F, A, 2, 1 on digits 0..3 -> word 16'h12AF
    logic [6:0] rot_seg [4] = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};
    logic [3:0] rot_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_decoder #(.STABLE_CNT(1), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg1), .anodes_in(an1),
        .value(value1), .value_valid(valid1), .digit_err(err1), .stale(stale1)
    );

    seg_scan_decoder #(.STABLE_CNT(3), .TIMEOUT(20)) dut3 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg3), .anodes_in(an3),
        .value(value3), .value_valid(valid3), .digit_err(err3), .stale(stale3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive1(input logic [6:0] s, input logic [3:0] a);
        seg1 = s;
        an1  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic [6:0] s, input logic [3:0] a);
        seg3 = s;
        an3  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        seg1 = 7'd0; an1 = 4'b1111;
        seg3 = 7'd0; an3 = 4'b1111;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        seg1 = 7'd0; an1 = 4'b1111;
        seg3 = 7'd0; an3 = 4'b1111;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({value1, valid1, err1, stale1, value3, valid3, err3, stale3} !== 38'd0) begin
            errors++;
            $display("FAIL reset_values: got %h/%b%b%b %h/%b%b%b, want all zero",
                     value1, valid1, err1, stale1, value3, valid3, err3, stale3);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rotate;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < 4; d++) begin
                logic [16:0] exp;
                drive1(rot_seg[d], rot_an[d]);
                exp = {(d == 3), ((f == 0 && d < 3) ? 16'h0000 : 16'h12AF)};
                checks++;
                if ({valid1, value1} !== exp) begin
                    errors++;
                    $display("FAIL rotate f%0d d%0d: got valid=%b value=%h, want valid=%b value=%h",
                             f, d, valid1, value1, exp[16], exp[15:0]);
                end
            end
        end
    endtask

    task automatic test_stable_hold;
        int  n;
        logic saw_valid;
        n = 0;
        saw_valid = 1'b0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 4; d++) begin
                for (int h = 0; h < 2; h++) begin
                    drive3(rot_seg[d], rot_an[d]);
                    n++;
                    if (valid3) saw_valid = 1'b1;
                    checks++;
                    if (stale3 !== (n >= 20)) begin
                        errors++;
                        $display("FAIL stale_timing cycle %0d: got %b, want %b", n, stale3, (n >= 20));
                    end
                end
            end
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_hold_no_valid: got valid pulse=%b, want 0", saw_valid);
        end
        for (int d = 0; d < 4; d++) begin
            for (int h = 0; h < 3; h++) begin
                drive3(rot_seg[d], rot_an[d]);
                checks++;
                if (d == 3 && h == 2) begin
                    if ({valid3, stale3, value3} !== {1'b1, 1'b0, 16'h12AF}) begin
                        errors++;
                        $display("FAIL long_hold_complete: got valid=%b stale=%b value=%h, want 1 0 12af",
                                 valid3, stale3, value3);
                    end
                end else begin
                    if ({valid3, stale3} !== 2'b01) begin
                        errors++;
                        $display("FAIL long_hold d%0d h%0d: got valid=%b stale=%b, want 0 1",
                                 d, h, valid3, stale3);
                    end
                end
            end
        end
    endtask

    task automatic test_bad_pattern;
        do_reset();
        for (int d = 0; d < 3; d++) drive1(rot_seg[d], rot_an[d]);
        drive1(7'b0000001, 4'b1011);
        checks++;
        if ({err1, valid1} !== 2'b10) begin
            errors++;
            $display("FAIL bad_pattern_err: got err=%b valid=%b, want 1 0", err1, valid1);
        end
        drive1(rot_seg[3], rot_an[3]);
        checks++;
        if ({err1, valid1} !== 2'b00) begin
            errors++;
            $display("FAIL bad_pattern_wait: got err=%b valid=%b, want 0 0", err1, valid1);
        end
        drive1(rot_seg[2], rot_an[2]);
        checks++;
        if ({valid1, value1} !== {1'b1, 16'h12AF}) begin
            errors++;
            $display("FAIL bad_pattern_recover: got valid=%b value=%h, want 1 12af", valid1, value1);
        end
    endtask

    task automatic test_illegal_anodes;
        do_reset();
        for (int d = 0; d < 3; d++) drive1(rot_seg[d], rot_an[d]);
        drive1(7'b1111110, 4'b1100);
        checks++;
        if ({err1, valid1} !== 2'b10) begin
            errors++;
            $display("FAIL illegal_anodes_err: got err=%b valid=%b, want 1 0", err1, valid1);
        end
        drive1(7'b1111110, 4'b1111);
        checks++;
        if ({err1, valid1} !== 2'b00) begin
            errors++;
            $display("FAIL blank_ignored: got err=%b valid=%b, want 0 0", err1, valid1);
        end
        drive1(rot_seg[3], rot_an[3]);
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clears_seen: got valid=%b, want 0", valid1);
        end
        for (int d = 0; d < 3; d++) begin
            drive1(rot_seg[d], rot_an[d]);
            checks++;
            if (valid1 !== (d == 2)) begin
                errors++;
                $display("FAIL illegal_refill d%0d: got valid=%b, want %b", d, valid1, (d == 2));
            end
        end
        checks++;
        if (value1 !== 16'h12AF) begin
            errors++;
            $display("FAIL illegal_refill_value: got %h, want 12af", value1);
        end
    endtask

    task automatic test_alias;
        logic exp_err;
`ifdef SEGDEC_ALIAS_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        do_reset();
        drive1(7'b1110011, 4'b1110);
        checks++;
        if (err1 !== exp_err) begin
            errors++;
            $display("FAIL alias_err: got %b, want %b", err1, exp_err);
        end
        for (int d = 1; d < 4; d++) drive1(rot_seg[d], rot_an[d]);
        checks++;
        if (valid1 !== !exp_err) begin
            errors++;
            $display("FAIL alias_frame_valid: got %b, want %b", valid1, !exp_err);
        end
        checks++;
        if (value1 !== (exp_err ? 16'h0000 : 16'h12A9)) begin
            errors++;
            $display("FAIL alias_value: got %h, want %h", value1, (exp_err ? 16'h0000 : 16'h12A9));
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [6:0] nseg [4];
        logic [3:0] nan  [4];
        int pulses;
        nseg = '{7'b1001110, 7'b1110000, 7'b1111111, 7'b1111011};
        nan  = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
        pulses = 0;
        do_reset();
        for (int d = 0; d < 4; d++) drive1(rot_seg[d], rot_an[d]);
        drive1(7'b1111001, 4'b1110);
        drive1(7'b0110011, 4'b1101);
        drive1(7'b1011011, 4'b1011);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({value1, valid1, err1, stale1} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got value=%h valid=%b err=%b stale=%b, want 0",
                     value1, valid1, err1, stale1);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) begin
            drive1(nseg[d], nan[d]);
            if (valid1) pulses++;
            checks++;
            if (valid1 !== (d == 3)) begin
                errors++;
                $display("FAIL post_reset d%0d: got valid=%b, want %b", d, valid1, (d == 3));
            end
        end
        checks++;
        if (value1 !== 16'hC987) begin
            errors++;
            $display("FAIL post_reset_value: got %h, want c987", value1);
        end
        for (int i = 0; i < 3; i++) begin
            drive1(7'd0, 4'b1111);
            if (valid1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL post_reset_pulse_count: got %0d, want 1", pulses);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        seg1 = 7'd0; an1 = 4'b1111;
        seg3 = 7'd0; an3 = 4'b1111;
        #3;
        test_reset();
        test_rotate();
        test_stable_hold();
        test_bad_pattern();
        test_illegal_anodes();
        test_alias();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
